// File: rtl/mux_nto1_reg.sv
// mux_nto1_reg: NCH-to-1 registered word mux with valid/ready, external-select or round-robin grant.
// Optional even-parity output out_par when MUX_NTO1_PARITY_EN is defined.
module mux_nto1_reg #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef MUX_NTO1_PARITY_EN
  , output logic               out_par
`endif
);
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d, out_chan_q, out_chan_d, gidx;
  logic [WIDTH-1:0] out_data_q, out_data_d, word;
  logic             out_valid_q, out_valid_d, load, gnt, xfer;

  // Round-robin wrap at NCH, not at 2^SELW.
  function automatic int rr_idx(input int p, input int k);
    return (p + k >= NCH) ? p + k - NCH : p + k;
  endfunction

  always_comb begin
    gnt  = 1'b0;
    gidx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (mode ? in_valid[rr_idx(int'(rr_ptr_q), k)] : (SELW'(k) == sel && in_valid[k])) begin
        gnt  = 1'b1;
        gidx = mode ? SELW'(rr_idx(int'(rr_ptr_q), k)) : sel;
      end
    end
    load        = !out_valid_q || out_ready;
    xfer        = load && gnt && !reset;
    in_ready    = xfer ? (NCH'(1) << gidx) : '0;
    word        = in_data[gidx*WIDTH +: WIDTH];
    out_valid_d = load ? gnt : out_valid_q;
    out_data_d  = xfer ? word : out_data_q;
    out_chan_d  = xfer ? gidx : out_chan_q;
    rr_ptr_d    = (xfer && mode) ? ((gidx == SELW'(NCH - 1)) ? '0 : gidx + SELW'(1)) : rr_ptr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

`ifdef MUX_NTO1_PARITY_EN
  logic out_par_q, out_par_d;

  always_comb out_par_d = xfer ? ^word : out_par_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_par_q <= 1'b0;
    else       out_par_q <= out_par_d;
  end

  assign out_par = out_par_q;
`endif

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_nto1_reg.sv
// tb_mux_nto1_reg: directed bench for a 4-channel and a 3-channel mux sharing one stimulus, checked against a cycle model.
module tb_mux_nto1_reg;
  logic         clk = 1'b0, reset = 1'b1, mode = 1'b0, out_ready = 1'b0;
  logic [1:0]   sel = '0;
  logic [127:0] in_data = '0;
  logic [3:0]   in_valid = '0;
  logic [3:0]   rdy4;
  logic [2:0]   rdy3;
  logic [31:0]  od4, od3;
  logic [1:0]   oc4, oc3;
  logic         ov4, ov3;
`ifdef MUX_NTO1_PARITY_EN
  logic         op4, op3;
`endif
  int n_cmp = 0, n_err = 0;

  bit          m_v[2] = '{0, 0};
  logic [31:0] m_d[2] = '{0, 0};
  int          m_c[2] = '{0, 0};
  int          m_p[2] = '{0, 0};

  always #5 clk = ~clk;

  mux_nto1_reg #(.WIDTH(32), .NCH(4), .SELW(2)) u4 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy4),
    .mode(mode), .sel(sel), .out_data(od4), .out_chan(oc4), .out_valid(ov4), .out_ready(out_ready)
`ifdef MUX_NTO1_PARITY_EN
    , .out_par(op4)
`endif
  );

  mux_nto1_reg #(.WIDTH(32), .NCH(3), .SELW(2)) u3 (
    .clk(clk), .reset(reset), .in_data(in_data[95:0]), .in_valid(in_valid[2:0]), .in_ready(rdy3),
    .mode(mode), .sel(sel), .out_data(od3), .out_chan(oc3), .out_valid(ov3), .out_ready(out_ready)
`ifdef MUX_NTO1_PARITY_EN
    , .out_par(op3)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic int exp_grant(input int nch, input int d);
    if (!mode) return (int'(sel) < nch && in_valid[sel]) ? int'(sel) : -1;
    for (int k = 0; k < nch; k++)
      if (in_valid[(m_p[d] + k) % nch]) return (m_p[d] + k) % nch;
    return -1;
  endfunction

  function automatic logic [3:0] exp_rdy(input int d);
    int g;
    g = exp_grant(d ? 3 : 4, d);
    if (reset || !(!m_v[d] || out_ready) || g < 0) return 4'b0;
    return 4'b1 << g;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_v[d] = 0; m_d[d] = '0; m_c[d] = 0; m_p[d] = 0;
      end else if (!m_v[d] || out_ready) begin
        int g;
        g = exp_grant(d ? 3 : 4, d);
        m_v[d] = (g >= 0);
        if (g >= 0) begin
          m_d[d] = in_data[g*32 +: 32];
          m_c[d] = g;
          if (mode) m_p[d] = (g + 1) % (d ? 3 : 4);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("rdy4", 64'(rdy4), 64'(exp_rdy(0)));
    chk("rdy3", 64'(rdy3), 64'(exp_rdy(1) & 4'b0111));
    chk("ov4", 64'(ov4), 64'(m_v[0]));
    chk("ov3", 64'(ov3), 64'(m_v[1]));
    chk("od4", 64'(od4), 64'(m_d[0]));
    chk("od3", 64'(od3), 64'(m_d[1]));
    chk("oc4", 64'(oc4), 64'(m_c[0]));
    chk("oc3", 64'(oc3), 64'(m_c[1]));
`ifdef MUX_NTO1_PARITY_EN
    chk("op4", 64'(op4), 64'(^m_d[0]));
    chk("op3", 64'(op3), 64'(^m_d[1]));
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    in_data = {32'h3333_0003, 32'hDEAD_BEEF, 32'h1111_0001, 32'h0000_A0A0};
    cyc(); cyc();
    reset = 1'b0;
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    #1 chk("m0_rdy_0100", 64'(rdy4), 64'h4);
    cyc(); #1;
    chk("m0_data", 64'(od4), 64'hDEADBEEF);
    chk("m0_chan", 64'(oc4), 64'd2);
    sel = 2'd1; in_valid = 4'b1101;
    #1 chk("m0_sel_invalid_rdy", 64'(rdy4), 64'h0);
    cyc(); #1 chk("m0_drain_ov", 64'(ov4), 64'h0);
    mode = 1'b1; in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      cyc(); #1;
      chk("rr4_chan", 64'(oc4), 64'(k % 4));
      chk("rr3_chan", 64'(oc3), 64'(k % 3));
    end
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      cyc(); #1 chk("rr_skip_chan", 64'(oc4), (k % 2) ? 64'd3 : 64'd1);
    end
    in_valid = 4'b1111;
    cyc(); #1 chk("bp_load_chan", 64'(oc4), 64'd0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_rdy", 64'(rdy4), 64'h0);
      chk("bp_data", 64'(od4), 64'h0000A0A0);
      cyc();
    end
    out_ready = 1'b1;
    #1 chk("bp_release_rdy", 64'(rdy4), 64'h2);
    cyc(); #1 chk("bp_release_chan", 64'(oc4), 64'd1);
    mode = 1'b0; sel = 2'd3;
    #1;
    chk("n3_sel3_rdy", 64'(rdy3), 64'h0);
    chk("n4_sel3_rdy", 64'(rdy4), 64'h8);
    cyc(); #1 chk("n3_sel3_drain", 64'(ov3), 64'h0);
`ifdef MUX_NTO1_PARITY_EN
    sel = 2'd0; in_valid = 4'b0000;
    cyc();
    in_data[31:0] = 32'h7; in_valid = 4'b0001;
    cyc(); #1;
    chk("par7_ov", 64'(ov4), 64'h1);
    chk("par7", 64'(op4), 64'h1);
    in_valid = 4'b0000;
    cyc();
    in_data[31:0] = 32'h3; in_valid = 4'b0001;
    cyc(); #1;
    chk("par3_ov", 64'(ov4), 64'h1);
    chk("par3", 64'(op4), 64'h0);
`endif
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
    cyc();
    reset = 1'b1;
    #1;
    chk("rst_ov", 64'(ov4), 64'h0);
    chk("rst_od", 64'(od4), 64'h0);
    chk("rst_oc", 64'(oc4), 64'h0);
    chk("rst_rdy4", 64'(rdy4), 64'h0);
    chk("rst_rdy3", 64'(rdy3), 64'h0);
    out_ready = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    cyc(); #1 chk("rst_ptr_chan", 64'(oc4), 64'd0);
    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mux_nto1_reg.md
Name: mux_nto1_reg

Overview:
- Parametrised successor to the datapath 2:1 word mux.
- Selects one of NCH input channels, each WIDTH bits wide, and carries the word over a valid/ready handshake.
- Registers the selected word in a single output stage.
- Two selection modes: external select (legacy mux behaviour) or round-robin arbitration.
- Used wherever several producers share one datapath consumer, such as write-back source selection and shared-bus arbitration.

Parameters:
- WIDTH, 32, bits per channel word
- NCH, 4, number of input channels (2..16)
- SELW, 2, select/channel index width; must equal ceil(log2(NCH))

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NCH  channel i has a word
- in_ready  output  NCH  channel i word is accepted this cycle
- mode  input  1  0 = external select, 1 = round-robin
- sel  input  SELW  channel index used when mode=0
- out_data  output  WIDTH  registered selected word
- out_chan  output  SELW  index of the channel that supplied out_data
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts out_data

Behaviour:
- Reset, asynchronous on posedge reset:
  - out_valid=0, out_data=0, out_chan=0, rr_ptr=0.
  - in_ready is 0 while reset is high.
- Output register load enable: load = !out_valid || out_ready. Single stage, no skid buffer.
- Grant when load=1:
  - mode=0: grant channel sel, only if sel<NCH and in_valid[sel]=1. Otherwise no grant.
  - mode=1: grant the first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NCH. No valid channel means no grant.
- in_ready[i] = load && grant && (i == granted index). At most one in_ready bit is high per cycle.
- in_ready depends combinationally on out_ready, mode, sel and in_valid. No combinational path exists from in_data to any output.
- Transfer on channel i: in_valid[i] && in_ready[i]. Next cycle:
  - out_data = that channel's word.
  - out_chan = i.
  - out_valid = 1.
- If out_ready=1 and there is no transfer: out_valid goes to 0 next cycle; out_data and out_chan hold their values.
- If out_valid=1 and out_ready=0: the register holds; all in_ready are 0.
- Simultaneous drain and fill (out_valid=1, out_ready=1, transfer): the new word replaces the old in one cycle. Throughput is 1 word/cycle.
- Latency: 1 cycle from accepted input to out_valid.
- rr_ptr updates only on a transfer in mode=1: rr_ptr = (granted+1) mod NCH, with wrap from NCH-1 to 0. Non-power-of-2 NCH wraps at NCH, not at 2^SELW.
- rr_ptr is unchanged in mode=0.
- Mode or sel changes take effect in the same cycle's grant. A word already held in the output register is unaffected.
- Reset asserted mid-transfer: the held word is discarded and out_valid drops immediately (asynchronous). The upstream sees no acceptance for that cycle.

Optional Feature:
- Macro: MUX_NTO1_PARITY_EN
- Defined:
  - Extra output out_par (1 bit) = XOR of all out_data bits, i.e. even parity, registered together with out_data.
  - Reset value of out_par is 0.
  - out_par updates on exactly the same cycles as out_data.
- Undefined: the out_par port does not exist and no parity logic is built. All other behaviour is identical.

Test Plan:
- Reset check: assert reset mid-simulation while out_valid=1 -> out_valid, out_data and out_chan go to 0 immediately; in_ready=0000 while reset is high.
- Mode 0 select, NCH=4:
  - Setup: sel=2, all valid, ch2=0xDEADBEEF, out_ready=1.
  - Response: in_ready=0100; next cycle out_data=0xDEADBEEF, out_chan=2.
  - sel=1 with in_valid[1]=0 -> in_ready=0000 and out_valid drops after the drain.
- Round-robin fairness: mode=1, all four valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,1,… with one transfer per cycle.
- Round-robin skip: in_valid=1010, rr_ptr=0 -> grants 1,3,1,3.
- Backpressure:
  - out_ready=0 for 3 cycles after a load -> out_data stable, in_ready=0000, rr_ptr unchanged.
  - On release, the next grant follows the pointer.
- Non-power-of-2: NCH=3, SELW=2, mode=1, all valid -> out_chan 0,1,2,0 (never 3).
  - mode=0 with sel=3 -> no grant.
- Parity (with MUX_NTO1_PARITY_EN): word 0x00000007 -> out_par=1; word 0x00000003 -> out_par=0, on the same cycle out_valid rises.
